// File: rtl/mips_dmem_ctrl.sv
// rtl/mips_dmem_ctrl.sv - stall-handshake data memory controller with wait states, byte enables and an I/O window
module mips_dmem_ctrl #(
    parameter int          DATA_W      = 32,
    parameter int          RAM_DEPTH   = 64,
    parameter int          WAIT_STATES = 1,
    parameter int          NUM_GPO     = 4,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic                      req_we,
    input  logic [31:0]               req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_be,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      stall,
    output logic [NUM_GPO*DATA_W-1:0] gpo,
    input  logic [DATA_W-1:0]         gpi,
    output logic                      err
);
    localparam int         BE_W      = DATA_W / 8;
    localparam int         RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                wcnt_q, wcnt_d;
    logic                      we_q, we_d;
    logic [31:0]               addr_q, addr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [BE_W-1:0]           be_q, be_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;
    logic [NUM_GPO*DATA_W-1:0] gpo_q, gpo_d;
    logic                      err_q, err_d;
    logic [31:0]               cnt_q, cnt_d;

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    logic              a_we, mis, is_io, io_bad, do_acc;
    logic [31:0]       a_addr_raw, a_addr, io_off;
    logic [DATA_W-1:0] a_wdata, rd_word;
    logic [BE_W-1:0]   a_be;
    logic [29:0]       io_idx;
    logic [RAM_AW-1:0] ram_idx;

    function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < BE_W; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // With zero wait states the access happens in the IDLE cycle itself, straight from the request
    always_comb begin
        if (state_q == S_IDLE) begin
            a_we       = req_we;
            a_addr_raw = req_addr;
            a_wdata    = req_wdata;
            a_be       = req_be;
        end else begin
            a_we       = we_q;
            a_addr_raw = addr_q;
            a_wdata    = wdata_q;
            a_be       = be_q;
        end
        a_addr  = {a_addr_raw[31:2], 2'b00};
        mis     = |a_addr_raw[1:0];
        is_io   = a_addr >= IO_BASE;
        io_off  = a_addr - IO_BASE;
        io_idx  = 30'(io_off >> 2);
        ram_idx = a_addr[RAM_AW+1:2];
        do_acc  = (state_q == S_IDLE && req_valid && WAIT_STATES == 0) ||
                  (state_q == S_WAIT && wcnt_q == 4'd0);

        rd_word = '0;
        io_bad  = 1'b0;
        if (!is_io) begin
            rd_word = mem[ram_idx];
        end else if (io_idx < 30'(NUM_GPO)) begin
            for (int k = 0; k < NUM_GPO; k++)
                if (io_idx == 30'(k)) rd_word = gpo_q[k*DATA_W +: DATA_W];
        end else if (io_idx == 30'(NUM_GPO)) begin
            rd_word = gpi;
        end else if (io_idx == 30'(NUM_GPO + 1)) begin
            rd_word = DATA_W'(cnt_q);
        end else begin
            io_bad = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        gpo_d   = gpo_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q + 32'd1;

        case (state_q)
            S_IDLE: if (req_valid) begin
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                be_d    = req_be;
                wcnt_d  = WCNT_INIT;
                state_d = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
                else                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_acc) begin
            err_d = mis | io_bad;
            if (!a_we) rdata_d = rd_word;
            else if (is_io)
                for (int k = 0; k < NUM_GPO; k++)
                    if (io_idx == 30'(k))
                        gpo_d[k*DATA_W +: DATA_W] = merge_be(gpo_q[k*DATA_W +: DATA_W], a_wdata, a_be);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            gpo_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            gpo_q   <= gpo_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is not reset; a store caught by reset is simply dropped
    always_ff @(posedge clk) begin
        if (reset && do_acc && a_we && !is_io)
            mem[ram_idx] <= merge_be(mem[ram_idx], a_wdata, a_be);
    end

    assign stall     = reset && ((state_q == S_IDLE && req_valid) || state_q == S_WAIT);
    assign rsp_rdata = rdata_q;
    assign gpo       = gpo_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// tb/tb_mips_dmem_ctrl.sv - self-checking bench for mips_dmem_ctrl at wait states 1, 3 and 0
module tb_mips_dmem_ctrl;
    localparam logic [31:0] IO = 32'hFFFF_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n   [3];
    logic         req_valid [3];
    logic         req_we    [3];
    logic [31:0]  req_addr  [3];
    logic [31:0]  req_wdata [3];
    logic [3:0]   req_be    [3];
    logic [31:0]  rsp_rdata [3];
    logic         stall     [3];
    logic [127:0] gpo       [3];
    logic         err       [3];
    logic [31:0]  gpi;

    int checks = 0;
    int errors = 0;

    // Instance 0: 1 wait state, instance 1: 3 wait states, instance 2: 0 wait states
    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips_dmem_ctrl #(
            .DATA_W(32), .RAM_DEPTH(64),
            .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 3 : 0),
            .NUM_GPO(4), .IO_BASE(IO)
        ) u_dut (
            .clk(clk), .reset(reset_n[g]),
            .req_valid(req_valid[g]), .req_we(req_we[g]), .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]), .req_be(req_be[g]), .rsp_rdata(rsp_rdata[g]),
            .stall(stall[g]), .gpo(gpo[g]), .gpi(gpi), .err(err[g])
        );
    end

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] exp_rd, input bit exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one request, scrambles the request fields while the access is in WAIT,
    // and returns the DONE-cycle outputs plus the number of stalled cycles.
    task automatic access(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic e, output int n);
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
        #1;
        n = 0;
        while (stall[d] === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            if (stall[d] === 1'b1) begin
                req_we[d] = ~we; req_addr[d] = ~addr; req_wdata[d] = ~wdata; req_be[d] = ~be;
            end
        end
        rdata = rsp_rdata[d];
        e     = err[d];
        req_valid[d] = 1'b0;
    endtask

    logic [31:0] rd, r1, r2;
    logic        e;
    int          n;

    initial begin
        gpi = 32'h0000_5A5A;
        for (int i = 0; i < 3; i++) begin
            reset_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0;
        end
        req_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_stall%0d", i), stall[i], 1'b0);
            check($sformatf("reset_rdata%0d", i), rsp_rdata[i], 32'h0);
            check($sformatf("reset_err%0d", i), err[i], 1'b0);
            check($sformatf("reset_gpo%0d", i), gpo[i], 128'h0);
        end
        req_valid[1] = 1'b0;
        for (int i = 0; i < 3; i++) reset_n[i] = 1'b1;

        vt.push_back(mk(1, 32'h10,       32'h1234_5678, 4'hF, 32'h0,         0));
        vt.push_back(mk(0, 32'h10,       32'h0,         4'hF, 32'h1234_5678, 0));
        vt.push_back(mk(1, 32'h0,        32'hAABB_CCDD, 4'hF, 32'h1234_5678, 0));
        vt.push_back(mk(1, 32'h0,        32'h1122_3344, 4'h5, 32'h1234_5678, 0));
        vt.push_back(mk(0, 32'h0,        32'h0,         4'hF, 32'hAA22_CC44, 0));
        vt.push_back(mk(1, IO + 32'h4,   32'h0000_CAFE, 4'hF, 32'hAA22_CC44, 0));
        vt.push_back(mk(0, IO + 32'h4,   32'h0,         4'hF, 32'h0000_CAFE, 0));
        vt.push_back(mk(0, IO + 32'h10,  32'h0,         4'hF, 32'h0000_5A5A, 0));
        vt.push_back(mk(1, IO + 32'h10,  32'hFFFF_FFFF, 4'hF, 32'h0000_5A5A, 0));
        vt.push_back(mk(0, IO + 32'h10,  32'h0,         4'hF, 32'h0000_5A5A, 0));
        vt.push_back(mk(0, 32'h13,       32'h0,         4'hF, 32'h1234_5678, 1));
        vt.push_back(mk(0, IO + 32'h40,  32'h0,         4'hF, 32'h0,         1));
        vt.push_back(mk(0, 32'h100,      32'h0,         4'hF, 32'hAA22_CC44, 0));
        vt.push_back(mk(1, 32'h102,      32'hDEAD_BEEF, 4'hF, 32'hAA22_CC44, 1));
        vt.push_back(mk(0, 32'h0,        32'h0,         4'hF, 32'hDEAD_BEEF, 0));
        vt.push_back(mk(1, 32'h4,        32'h0102_0304, 4'hF, 32'hDEAD_BEEF, 0));
        vt.push_back(mk(1, 32'h4,        32'hFFFF_FFFF, 4'h0, 32'hDEAD_BEEF, 0));
        vt.push_back(mk(0, 32'h4,        32'h0,         4'hF, 32'h0102_0304, 0));
        vt.push_back(mk(1, IO + 32'h40,  32'h1234_5678, 4'hF, 32'h0102_0304, 1));
        vt.push_back(mk(1, IO,           32'hA1B2_C3D4, 4'hC, 32'h0102_0304, 0));
        vt.push_back(mk(0, IO,           32'h0,         4'hF, 32'hA1B2_0000, 0));
        vt.push_back(mk(0, IO + 32'h8,   32'h0,         4'hF, 32'h0,         0));

        foreach (vt[i]) begin
            access(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, e, n);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_err", i), e, vt[i].exp_err);
            check($sformatf("vec%0d_stall_cycles", i), n, 2);
        end
        check("gpo_final", gpo[0], {32'h0, 32'h0, 32'h0000_CAFE, 32'hA1B2_0000});

        access(0, 1'b0, 32'h13, 32'h0, 4'hF, rd, e, n);
        check("mis_err_pulse", e, 1'b1);
        @(negedge clk);
        check("mis_err_one_cycle", err[0], 1'b0);

        // Reset in the second WAIT cycle of a 3-wait-state store
        access(1, 1'b1, IO, 32'h77, 4'hF, rd, e, n);
        check("ws3_stall_cycles", n, 4);
        check("ws3_gpo_written", gpo[1][31:0], 32'h77);
        access(1, 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, rd, e, n);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
        req_wdata[1] = 32'h1111_1111; req_be[1] = 4'hF;
        @(negedge clk);
        @(negedge clk);
        reset_n[1] = 1'b0;
        req_valid[1] = 1'b0;
        #1;
        check("rst_mid_stall_low", stall[1], 1'b0);
        @(negedge clk);
        check("rst_mid_gpo", gpo[1], 128'h0);
        check("rst_mid_rdata", rsp_rdata[1], 32'h0);
        reset_n[1] = 1'b1;
        #1;
        check("rst_mid_idle", stall[1], 1'b0);
        access(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, e, n);
        check("rst_mid_ram_kept", rd, 32'h0BAD_F00D);
        check("rst_mid_stall_cycles", n, 4);

        // Counter reads back-to-back with zero wait states
        access(2, 1'b0, IO + 32'h14, 32'h0, 4'hF, r1, e, n);
        check("ws0_stall_cycles", n, 1);
        access(2, 1'b0, IO + 32'h14, 32'h0, 4'hF, r2, e, n);
        check("cnt_diff", r2 - r1, 32'd2);

        @(negedge clk);
        force g_dut[2].u_dut.cnt_q = 32'hFFFF_FFFF;
        req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = IO + 32'h14;
        #1;
        release g_dut[2].u_dut.cnt_q;
        @(negedge clk);
        check("cnt_pre_wrap", rsp_rdata[2], 32'hFFFF_FFFF);
        req_valid[2] = 1'b0;
        access(2, 1'b0, IO + 32'h14, 32'h0, 4'hF, rd, e, n);
        check("cnt_post_wrap", rd, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
